em4100_rx: RTL and testbench

Receive-side decoder for the EM4100 64-bit RFID frame. Oversamples a Manchester-coded line (e.g. the demodulated card or emulator output) on the system clock, recovers bit timing from edges, hunts for the 9-ones header, and checks the 50 row bits, 4 column-parity bits and stop bit. It then presents the 40-bit ID with a one-cycle valid strobe, or a one-cycle error strobe. It sits between the analogue front-end comparator and the host/ID-matching logic.

---
 rtl/em4100_rx.sv | 194 +++++++++++++++++++
 tb/tb_em4100_rx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/em4100_rx.sv
// em4100_rx: EM4100 Manchester receive decoder.
// Recovers bit timing from line edges, hunts the header and validates the frame.
module em4100_rx #(
    parameter int HALF_BIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        din,
    output logic [39:0] id,
    output logic        valid,
    output logic        err,
    output logic        locked
);
    localparam int TW = $clog2(4*HALF_BIT+1);
    localparam logic [TW-1:0] T_SHORT = TW'(HALF_BIT/2);
    localparam logic [TW-1:0] T_LONG  = TW'(3*HALF_BIT/2);
    localparam logic [TW-1:0] T_BAD   = TW'(5*HALF_BIT/2);
    localparam logic [TW-1:0] T_MAX   = TW'(4*HALF_BIT);

    typedef enum logic [1:0] {UNLOCK, MID, EDGE} bstate_t;
    typedef enum logic [1:0] {HUNT, DATA, CHECK} fstate_t;
    typedef enum logic [1:0] {C_NONE, C_SHORT, C_LONG, C_BAD} cls_t;

    logic          sync1, sync2, prev;
    logic [TW-1:0] tmr, ivl;
    logic          edge_seen, timeout;
    cls_t          cls;
    bstate_t       bs;
    logic          bit_vld, bit_val;
    fstate_t       fs;
    logic [3:0]    ones;
    logic [5:0]    idx;
    logic [54:0]   sr;
    logic          frame_ok;
    logic [39:0]   frame_id;
    logic [3:0]    nib, col_par;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // ivl is the number of clocks since the previous edge, including this one
    assign edge_seen = sync2 ^ prev;
    assign ivl       = tmr + 1'b1;
    assign timeout   = !edge_seen && (ivl == T_BAD);

    always_comb begin
        cls = C_NONE;
        if (edge_seen) begin
            if (ivl >= T_SHORT && ivl < T_LONG)
                cls = C_SHORT;
            else if (ivl >= T_LONG && ivl < T_BAD)
                cls = C_LONG;
            else
                cls = C_BAD;
        end else if (timeout) begin
            cls = C_BAD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            bs      <= UNLOCK;
            tmr     <= '0;
            bit_vld <= 1'b0;
            bit_val <= 1'b0;
        end else begin
            bit_vld <= 1'b0;
            if (edge_seen)
                tmr <= '0;
            else if (tmr != T_MAX)
                tmr <= tmr + 1'b1;
            unique case (bs)
                UNLOCK: begin
                    if (cls == C_LONG) begin
                        bs      <= MID;
                        bit_vld <= 1'b1;
                        bit_val <= sync2;
                    end
                end
                MID: begin
                    unique case (cls)
                        C_SHORT: bs <= EDGE;
                        C_LONG: begin
                            bit_vld <= 1'b1;
                            bit_val <= sync2;
                        end
                        C_BAD:   bs <= UNLOCK;
                        default: ;
                    endcase
                end
                EDGE: begin
                    unique case (cls)
                        C_SHORT: begin
                            bs      <= MID;
                            bit_vld <= 1'b1;
                            bit_val <= sync2;
                        end
                        C_LONG, C_BAD: bs <= UNLOCK;
                        default: ;
                    endcase
                end
                default: bs <= UNLOCK;
            endcase
        end
    end

    assign locked = (bs != UNLOCK);

    always_comb begin
        frame_ok = 1'b1;
        frame_id = '0;
        col_par  = '0;
        nib      = '0;
        for (int r = 0; r < 10; r++) begin
            nib = sr[54-5*r -: 4];
            frame_id[39-4*r -: 4] = nib;
            col_par = col_par ^ nib;
            if ((^nib) != sr[50-5*r])
                frame_ok = 1'b0;
        end
        if (col_par != sr[4:1] || sr[0])
            frame_ok = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fs    <= HUNT;
            ones  <= '0;
            idx   <= '0;
            sr    <= '0;
            id    <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (!en) begin
                fs   <= HUNT;
                ones <= '0;
                idx  <= '0;
            end else begin
                unique case (fs)
                    HUNT: begin
                        if (bit_vld) begin
                            if (!bit_val) begin
                                ones <= '0;
                            end else if (ones == 4'd8) begin
                                fs   <= DATA;
                                ones <= '0;
                                idx  <= '0;
                            end else begin
                                ones <= ones + 1'b1;
                            end
                        end else if (!locked) begin
                            ones <= '0;
                        end
                    end
                    DATA: begin
                        if (!locked) begin
                            err <= 1'b1;
                            fs  <= HUNT;
                        end else if (bit_vld) begin
                            sr  <= {sr[53:0], bit_val};
                            idx <= idx + 1'b1;
                            if (idx == 6'd54)
                                fs <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (frame_ok) begin
                            id    <= frame_id;
                            valid <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        fs   <= HUNT;
                        ones <= '0;
                    end
                    default: fs <= HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_em4100_rx.sv
// tb_em4100_rx: plays generated Manchester streams into em4100_rx
// and checks strobes, id and lock against expected frame outcomes.
module tb_em4100_rx;
    localparam int H  = 16;
    localparam int BP = 2*H;
    localparam int K_VAL = 0, K_ERR = 1, K_RST = 2, K_LOSS = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b1;
    logic        din   = 1'b0;
    logic [39:0] id;
    logic        valid, err, locked;

    em4100_rx #(.HALF_BIT(H)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din),
        .id(id), .valid(valid), .err(err), .locked(locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        int          lo;
        int          hi;
        logic [39:0] v;
    } ev_t;

    bit          wq[$];
    bit          rq[$];
    bit          eq[$];
    ev_t         evq[$];
    bit          fb[64];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          cyc0 = 0;
    bit          started = 1'b0;
    logic [39:0] mid = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // transmission order: 9 ones, 10 rows (nibble MSB-first + even parity), CP3..CP0, stop
    function automatic void build(input logic [39:0] v, input int corrupt);
        logic [3:0] cp, n;
        cp = '0;
        for (int i = 0; i < 9; i++) fb[i] = 1'b1;
        for (int r = 0; r < 10; r++) begin
            n = v[39-4*r -: 4];
            for (int j = 0; j < 4; j++) fb[9+5*r+j] = n[3-j];
            fb[9+5*r+4] = ^n;
            cp = cp ^ n;
        end
        for (int j = 0; j < 4; j++) fb[59+j] = cp[3-j];
        fb[63] = 1'b0;
        if (corrupt == 1) fb[28] = ~fb[28];
        if (corrupt == 2) fb[63] = 1'b1;
    endfunction

    task automatic put(input bit w, input bit r, input bit e);
        wq.push_back(w);
        rq.push_back(r);
        eq.push_back(e);
    endtask

    task automatic put_bit(input bit b);
        for (int i = 0; i < H; i++) put(~b, 1'b1, 1'b1);
        for (int i = 0; i < H; i++) put(b, 1'b1, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put_bit(1'b0);
    endtask

    task automatic jitter(input int from, input int to, input int stop_nom,
                          output int stop_d);
        int edges[$];
        int d, dp, e;
        stop_d = 0;
        dp = 0;
        for (int i = from + 5; i < to - 5; i++)
            if (wq[i] != wq[i-1]) edges.push_back(i);
        foreach (edges[k]) begin
            e = edges[k];
            d = int'($urandom_range(8)) - 4;
            if (d - dp > 7 || dp - d > 7) d = 0;
            if (d > 0)
                for (int m = e; m < e + d; m++) wq[m] = wq[e-1];
            else if (d < 0)
                for (int m = e + d; m < e; m++) wq[m] = wq[e];
            if (e == stop_nom) stop_d = d;
            dp = d;
        end
    endtask

    // abort: 0 none, 1 stuck high after data bit 20, 2 reset at data bit 30, 3 en low there
    task automatic frame(input logic [39:0] v, input int corrupt,
                         input bit jit, input int abort);
        int  base, cut, sd, stop_e, s;
        ev_t ev;
        build(v, corrupt);
        base = wq.size();
        if (abort == 1) begin
            for (int i = 0; i < 30; i++) put_bit(fb[i]);
            cut = wq.size();
            for (int i = 0; i < 3*H; i++) put(1'b1, 1'b1, 1'b1);
            ev = '{K_LOSS, cut, cut + 3*H + 12, 40'h0};
            evq.push_back(ev);
        end else begin
            for (int i = 0; i < 64; i++) put_bit(fb[i]);
            stop_e = base + 63*BP + H;
            sd = 0;
            if (jit) jitter(base, wq.size(), stop_e, sd);
            s = base + 39*BP;
            if (abort == 2) begin
                rq[s] = 1'b0;
                ev = '{K_RST, s + 1, s + 1, 40'h0};
                evq.push_back(ev);
            end else if (abort == 3) begin
                for (int i = 0; i < 5; i++) eq[s+i] = 1'b0;
            end else begin
                ev = '{(corrupt != 0) ? K_ERR : K_VAL,
                       stop_e + sd + 5, stop_e + sd + 5, v};
                evq.push_back(ev);
            end
        end
    endtask

    always @(negedge clk) begin
        int  t;
        ev_t e;
        if (started) begin
            t = cyc - cyc0;
            while (evq.size() > 0 && evq[0].hi < t) begin
                checks++;
                errors++;
                $display("FAIL missed_strobe kind %0d actual none required by t=%0d",
                         evq[0].kind, evq[0].hi);
                void'(evq.pop_front());
            end
            if (evq.size() > 0 && evq[0].kind == K_RST && evq[0].lo == t) begin
                chk("reset_state", {21'b0, id, valid, err, locked}, 64'h0);
                mid = '0;
                void'(evq.pop_front());
            end
            if (valid || err) begin
                if (evq.size() == 0 || t < evq[0].lo || evq[0].kind == K_RST ||
                    (valid && evq[0].kind != K_VAL) ||
                    (err && evq[0].kind == K_VAL)) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe t=%0d actual valid=%b err=%b required none",
                             t, valid, err);
                end else begin
                    e = evq.pop_front();
                    if (valid) begin
                        chk("valid_id", 64'(id), 64'(e.v));
                        chk("valid_locked", 64'(locked), 64'd1);
                        mid = e.v;
                    end else begin
                        chk("err_locked", 64'(locked),
                            (e.kind == K_LOSS) ? 64'd0 : 64'd1);
                    end
                end
            end
            chk("id_hold", 64'(id), 64'(mid));
            chk("strobe_excl", 64'(valid & err), 64'd0);
        end
    end

    initial begin
        logic [39:0] r;
        int          n;
        build(40'h0123456789, 0);
        chk("model_cp", {60'b0, fb[59], fb[60], fb[61], fb[62]}, 64'h1);
        chk("model_row3_par", 64'(fb[28]), 64'd0);
        chk("model_row7_par", 64'(fb[48]), 64'd1);
        chk("model_nib1", {60'b0, fb[14], fb[15], fb[16], fb[17]}, 64'h1);
        n = 0;
        for (int i = 0; i < 10; i++) n += int'(fb[i]);
        chk("model_hdr", 64'(n), 64'd9);
        build(40'hFFFFFFFFFF, 0);
        chk("model_ff_cp", {60'b0, fb[59], fb[60], fb[61], fb[62]}, 64'h0);
        chk("model_ff_par", 64'(fb[13]), 64'd0);

        for (int i = 0; i < 4; i++) put(1'b0, 1'b0, 1'b1);
        evq.push_back('{K_RST, 1, 1, 40'h0});
        idle(2);
        frame(40'h0123456789, 0, 1'b0, 0);
        idle(2);
        frame(40'h0123456789, 1, 1'b0, 0);
        idle(2);
        frame(40'h0123456789, 0, 1'b1, 0);
        idle(2);
        frame(40'hFFFFFFFFFF, 0, 1'b0, 0);
        frame(40'h0000000000, 0, 1'b0, 0);
        idle(2);
        frame(40'hFFFFFFFFFF, 0, 1'b0, 0);
        frame(40'h0000000000, 2, 1'b0, 0);
        idle(2);
        frame({8'($urandom), $urandom}, 0, 1'b0, 1);
        idle(3);
        frame({8'($urandom), $urandom}, 0, 1'b0, 0);
        idle(2);
        frame({8'($urandom), $urandom}, 0, 1'b0, 2);
        idle(2);
        frame({8'($urandom), $urandom}, 0, 1'b0, 0);
        idle(2);
        frame({8'($urandom), $urandom}, 0, 1'b0, 3);
        idle(2);
        frame({8'($urandom), $urandom}, 0, 1'b0, 0);
        for (int k = 0; k < 4; k++) begin
            idle(int'($urandom_range(2)));
            r = {8'($urandom), $urandom};
            frame(r, int'($urandom_range(2)), 1'b1, 0);
        end
        idle(3);

        repeat (3) @(posedge clk);
        @(negedge clk);
        cyc0 = cyc;
        started = 1'b1;
        for (int i = 0; i < wq.size(); i++) begin
            din   = wq[i];
            rst_n = rq[i];
            en    = eq[i];
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        while (evq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_event kind %0d actual none required by t=%0d",
                     evq[0].kind, evq[0].hi);
            void'(evq.pop_front());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
